teclado_entrada: RTL and testbench
==================================

# teclado_entrada

Key-entry accumulator that consumes the keypad scanner's `digito`/`cambio_digito` output pair and turns raw scan events into discrete key presses. It builds a decimal number of up to `N_DIG` BCD digits and supports backspace (`E`) and enter (`F`). Command keys `A`–`D` are forwarded as one-cycle strobes. It sits between the keypad scanner and the application control/display logic, and runs on the same 100 Hz scan clock.

## Interface
- `N_DIG`, default 4: maximum digits held in the buffer.
- `T_SUELTA`, default 8: consecutive event-free cycles that declare a key released. Must be greater than 4, the scan period.

- `clk` input 1: scan clock, shared with the keypad scanner.
- `rst` input 1: reset, synchronous and active-high.
- `digito` input 5: key code from the scanner. 0–9 are digits, 0xA–0xD are commands, 0xE is backspace, 0xF is enter, 16 and 17 are invalid.
- `cambio_digito` input 1: toggles once per scan cycle in which a key is detected.
- `numero` output 4·N_DIG: live BCD buffer, least-significant digit in [3:0], for display.
- `cant_digitos` output 3: number of digits currently in the buffer (0..N_DIG).
- `numero_final` output 4·N_DIG: buffer value latched on enter.
- `num_valido` output 1: one-cycle strobe, asserted when `numero_final` updates.
- `tecla_cmd` output 4: last command key code (0xA–0xD).
- `cmd_valido` output 1: one-cycle strobe, asserted when `tecla_cmd` updates.
- `desborde` output 1: one-cycle strobe, asserted when a digit is rejected because the buffer is full.

## Operation
- Event detection:
  - `cambio_q` registers `cambio_digito` every cycle.
  - `evento = cambio_digito ^ cambio_q`.
  - Only the toggle is meaningful. The level of `cambio_digito` carries no information.
- FSM states:
  - LIBRE:
    - `evento` → process `digito` once, clear the release counter, go to PRESIONADA.
  - PRESIONADA:
    - `evento` → clear the release counter and stay. The held key's repeat toggles arrive every 4 cycles.
    - Any `digito` seen while in PRESIONADA is ignored, including a different key.
    - No `evento` → increment the counter. When it reaches `T_SUELTA-1`, go to LIBRE.
- Key processing (only on the LIBRE→PRESIONADA transition):
  - Digit 0–9, `cant_digitos < N_DIG`: `numero <= {numero[4·N_DIG-5:0], d}`, `cant_digitos++`.
  - Digit 0–9, buffer full: buffer unchanged, `desborde` pulses.
  - 0xE: if `cant_digitos > 0`, `numero <= numero >> 4` and `cant_digitos--`. Otherwise no effect.
  - 0xF with `cant_digitos > 0`: `numero_final <= numero`, `num_valido` pulses, `numero` and `cant_digitos` clear.
  - 0xF with `cant_digitos == 0`: no effect, no strobe.
  - 0xA–0xD: `tecla_cmd <= digito[3:0]`, `cmd_valido` pulses, buffer untouched.
  - 16, 17: ignored, but the FSM still enters PRESIONADA.
- All strobes are high for exactly one cycle per accepted key.

## Timing
- Reset values:
  - `numero`, `numero_final`, `cant_digitos`, `tecla_cmd`: 0.
  - All strobes: 0.
  - State: LIBRE, counter 0.
  - `cambio_q <= cambio_digito`, so the cycle after reset produces no spurious event.
- Latency:
  - If the input toggles in cycle k, outputs and strobes are visible in cycle k+1.
  - After the last toggle, LIBRE is re-entered after `T_SUELTA` event-free cycles.
- Boundary conditions:
  - Event on the same cycle the counter would expire: the event wins. The counter clears and the state stays PRESIONADA.
  - Reset mid-press: all state clears. A key still held afterwards is accepted as a new press on its next toggle.
  - Buffer full followed by 0xF: latches the full value normally.
  - `cant_digitos` never exceeds `N_DIG` and never goes below 0.

## Test plan
- Reset, then toggle with `digito`=5, 3, 7 in turn, each followed by 10 idle cycles → `numero`=0x0537, `cant_digitos`=3, no strobes.
- Continuing, toggle with 0xF → `num_valido` high for 1 cycle, `numero_final`=0x0537, `numero`=0, `cant_digitos`=0.
- Hold key 4 (toggle every 4 cycles for 40 cycles), then idle → exactly one digit accepted: `numero`=0x0004. Next key 2 accepted only after 8 idle cycles.
- Enter 1, 2, 3, 4, 5 with releases in between → `numero`=0x1234 and `desborde` pulses once on the 5th digit. Then 0xE → `numero`=0x0123, `cant_digitos`=3.
- Toggle with 0xB → `cmd_valido` pulses once, `tecla_cmd`=0xB, `numero` unchanged. 0xF with an empty buffer → no `num_valido`.
- Assert `rst` during a held key → all outputs 0, no event in the cycle after reset. The next toggle is accepted as a new key.

Source files
------------

// File: rtl/teclado_entrada_if.sv
// teclado_entrada_if: scanner-side key events in, accumulated number and strobes out
interface teclado_entrada_if #(
   parameter int N_DIG = 4
);
   logic [4:0] digito;
   logic cambio_digito;
   logic [4*N_DIG-1:0] numero;
   logic [2:0] cant_digitos;
   logic [4*N_DIG-1:0] numero_final;
   logic num_valido;
   logic [3:0] tecla_cmd;
   logic cmd_valido;
   logic desborde;
   modport master (
      output digito, cambio_digito,
      input numero, cant_digitos, numero_final, num_valido, tecla_cmd, cmd_valido, desborde
   );
   modport slave (
      input digito, cambio_digito,
      output numero, cant_digitos, numero_final, num_valido, tecla_cmd, cmd_valido, desborde
   );
endinterface

// File: rtl/teclado_entrada.sv
// teclado_entrada: turns scanner toggle events into key presses building a BCD number with backspace, enter and command strobes
module teclado_entrada #(
   parameter int N_DIG = 4,
   parameter int T_SUELTA = 8
) (
   input logic clk,
   input logic rst,
   teclado_entrada_if.slave bus
);
   localparam int W = 4 * N_DIG;
   localparam int CW = $clog2(T_SUELTA);
   typedef enum logic {LIBRE, PRESIONADA} estado_t;
   estado_t estado, estado_n;
   logic [CW-1:0] cnt, cnt_n;
   logic cambio_q, evento, acepta;
   logic [W-1:0] numero_n, final_n;
   logic [2:0] cant_n;
   logic [3:0] tecla_n;
   logic num_v_n, cmd_v_n, desb_n;
   assign evento = bus.cambio_digito ^ cambio_q;
   assign acepta = (estado == LIBRE) && evento;
   always_comb begin
      estado_n = estado;
      cnt_n = cnt;
      numero_n = bus.numero;
      cant_n = bus.cant_digitos;
      final_n = bus.numero_final;
      tecla_n = bus.tecla_cmd;
      num_v_n = 1'b0;
      cmd_v_n = 1'b0;
      desb_n = 1'b0;
      // a new event always restarts the release timer, even on its expiry cycle
      if (evento) begin
         estado_n = PRESIONADA;
         cnt_n = '0;
      end else if (estado == PRESIONADA) begin
         estado_n = (cnt == CW'(T_SUELTA - 1)) ? LIBRE : PRESIONADA;
         cnt_n = (cnt == CW'(T_SUELTA - 1)) ? '0 : cnt + 1'b1;
      end
      if (acepta) begin
         if (bus.digito < 5'd10) begin
            if (bus.cant_digitos < 3'(N_DIG)) begin
               numero_n = {bus.numero[W-5:0], bus.digito[3:0]};
               cant_n = bus.cant_digitos + 3'd1;
            end else
               desb_n = 1'b1;
         end else if (bus.digito == 5'hE) begin
            numero_n = (bus.cant_digitos != 3'd0) ? bus.numero >> 4 : bus.numero;
            cant_n = (bus.cant_digitos != 3'd0) ? bus.cant_digitos - 3'd1 : bus.cant_digitos;
         end else if (bus.digito == 5'hF) begin
            if (bus.cant_digitos != 3'd0) begin
               final_n = bus.numero;
               num_v_n = 1'b1;
               numero_n = '0;
               cant_n = 3'd0;
            end
         end else if (bus.digito < 5'h10) begin
            tecla_n = bus.digito[3:0];
            cmd_v_n = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      cambio_q <= bus.cambio_digito;
      if (rst) begin
         estado <= LIBRE;
         cnt <= '0;
         bus.numero <= '0;
         bus.cant_digitos <= 3'd0;
         bus.numero_final <= '0;
         bus.tecla_cmd <= 4'd0;
         bus.num_valido <= 1'b0;
         bus.cmd_valido <= 1'b0;
         bus.desborde <= 1'b0;
      end else begin
         estado <= estado_n;
         cnt <= cnt_n;
         bus.numero <= numero_n;
         bus.cant_digitos <= cant_n;
         bus.numero_final <= final_n;
         bus.tecla_cmd <= tecla_n;
         bus.num_valido <= num_v_n;
         bus.cmd_valido <= cmd_v_n;
         bus.desborde <= desb_n;
      end
   end
endmodule

// File: tb/tb_teclado_entrada.sv
// tb_teclado_entrada: directed key sequences with hand-computed expectations
module tb_teclado_entrada;
   logic clk;
   logic rst;
   int total = 0;
   int bad = 0;
   teclado_entrada_if bus ();
   teclado_entrada dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) tick();
   endtask
   task automatic toggle(input logic [4:0] d);
      bus.digito = d;
      bus.cambio_digito = ~bus.cambio_digito;
      tick();
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_strobes(input string tag, input logic nv, input logic cv, input logic ds);
      chk({tag, "_num_valido"}, 32'(bus.num_valido), 32'(nv));
      chk({tag, "_cmd_valido"}, 32'(bus.cmd_valido), 32'(cv));
      chk({tag, "_desborde"}, 32'(bus.desborde), 32'(ds));
   endtask
   initial begin
      rst = 1'b1;
      bus.digito = 5'd0;
      bus.cambio_digito = 1'b0;
      idle(2);
      rst = 1'b0;
      tick();
      chk("rst_numero", 32'(bus.numero), 32'h0);
      chk("rst_cant", 32'(bus.cant_digitos), 32'd0);
      chk("rst_final", 32'(bus.numero_final), 32'h0);
      chk("rst_tecla", 32'(bus.tecla_cmd), 32'h0);
      chk_strobes("rst", 1'b0, 1'b0, 1'b0);
      // three digits, each released
      toggle(5'd5);
      chk("d5_numero", 32'(bus.numero), 32'h0005);
      idle(10);
      toggle(5'd3);
      idle(10);
      toggle(5'd7);
      chk("d537_numero", 32'(bus.numero), 32'h0537);
      chk("d537_cant", 32'(bus.cant_digitos), 32'd3);
      chk_strobes("d537", 1'b0, 1'b0, 1'b0);
      idle(10);
      toggle(5'hF);
      chk_strobes("enter", 1'b1, 1'b0, 1'b0);
      chk("enter_final", 32'(bus.numero_final), 32'h0537);
      chk("enter_numero", 32'(bus.numero), 32'h0);
      chk("enter_cant", 32'(bus.cant_digitos), 32'd0);
      tick();
      chk("enter_pulse_end", 32'(bus.num_valido), 32'd0);
      idle(9);
      // held key 4: repeat toggles every 4 cycles
      toggle(5'd4);
      for (int i = 0; i < 9; i++) begin
         idle(3);
         toggle(5'd4);
      end
      chk("hold_numero", 32'(bus.numero), 32'h0004);
      chk("hold_cant", 32'(bus.cant_digitos), 32'd1);
      idle(7);
      toggle(5'd2);
      chk("early_key_ignored", 32'(bus.numero), 32'h0004);
      idle(8);
      toggle(5'd2);
      chk("after_release_numero", 32'(bus.numero), 32'h0042);
      chk("after_release_cant", 32'(bus.cant_digitos), 32'd2);
      idle(8);
      toggle(5'hF);
      chk("enter2_final", 32'(bus.numero_final), 32'h0042);
      chk("enter2_valid", 32'(bus.num_valido), 32'd1);
      idle(8);
      // overflow on the fifth digit
      for (int i = 1; i <= 5; i++) begin
         toggle(5'(i));
         chk($sformatf("ovf_desborde_%0d", i), 32'(bus.desborde), 32'(i == 5));
         idle(8);
         chk($sformatf("ovf_desborde_end_%0d", i), 32'(bus.desborde), 32'd0);
      end
      chk("full_numero", 32'(bus.numero), 32'h1234);
      chk("full_cant", 32'(bus.cant_digitos), 32'd4);
      toggle(5'hE);
      chk("bksp_numero", 32'(bus.numero), 32'h0123);
      chk("bksp_cant", 32'(bus.cant_digitos), 32'd3);
      idle(8);
      toggle(5'hB);
      chk_strobes("cmd", 1'b0, 1'b1, 1'b0);
      chk("cmd_tecla", 32'(bus.tecla_cmd), 32'hB);
      chk("cmd_numero", 32'(bus.numero), 32'h0123);
      tick();
      chk("cmd_pulse_end", 32'(bus.cmd_valido), 32'd0);
      idle(8);
      for (int i = 0; i < 4; i++) begin
         toggle(5'hE);
         idle(8);
      end
      chk("empty_numero", 32'(bus.numero), 32'h0);
      chk("empty_cant", 32'(bus.cant_digitos), 32'd0);
      toggle(5'hF);
      chk_strobes("enter_empty", 1'b0, 1'b0, 1'b0);
      chk("enter_empty_final", 32'(bus.numero_final), 32'h0042);
      idle(8);
      toggle(5'd16);
      chk("invalid_numero", 32'(bus.numero), 32'h0);
      chk_strobes("invalid", 1'b0, 1'b0, 1'b0);
      idle(8);
      // reset while key 9 is held, with a toggle landing in the reset cycle
      toggle(5'd9);
      chk("pre_rst_numero", 32'(bus.numero), 32'h0009);
      idle(2);
      rst = 1'b1;
      bus.cambio_digito = ~bus.cambio_digito;
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_numero", 32'(bus.numero), 32'h0);
      chk("midrst_cant", 32'(bus.cant_digitos), 32'd0);
      chk("midrst_final", 32'(bus.numero_final), 32'h0);
      chk("midrst_tecla", 32'(bus.tecla_cmd), 32'h0);
      chk_strobes("midrst", 1'b0, 1'b0, 1'b0);
      idle(2);
      toggle(5'd9);
      chk("post_rst_numero", 32'(bus.numero), 32'h0009);
      chk("post_rst_cant", 32'(bus.cant_digitos), 32'd1);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
